// File: rtl/game_of_life_core.sv
// Conway's Game of Life engine on an 80x60 toroidal grid with an 8x8-pixel VGA renderer.
// SDRAM pins are tied to an idle, deselected state.
module game_of_life_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        clkDiv,
   input  logic        displayActive,
   input  logic        noise,
   input  logic        drawRequest,
   input  logic        left,
   input  logic        right,
   input  logic [8:0]  row,
   input  logic [9:0]  column,
   output logic [2:0]  color,
   output logic [7:0]  led,
   input  logic        clk133_p,
   output logic [12:0] sd_A,
   output logic [1:0]  sd_BA,
   output logic        sd_RAS,
   output logic        sd_CAS,
   output logic        sd_WE,
   output logic        sd_CKE,
   output logic        sd_CS,
   output logic        sd_LDM,
   output logic        sd_UDM,
   inout  wire  [15:0] sd_DQ,
   inout  wire         sd_LDQS,
   inout  wire         sd_UDQS
);

   localparam int unsigned GRID_W = 80;
   localparam int unsigned GRID_H = 60;
   localparam int unsigned CELLS  = GRID_W * GRID_H;
   localparam int unsigned IDX_W  = 13;
   localparam int unsigned X_W    = 7;
   localparam int unsigned Y_W    = 6;

   localparam logic [2:0] LIVE_COLOR = 3'b010;
   localparam logic [2:0] DEAD_COLOR = 3'b000;

   localparam logic [1:0] ST_SEED    = 2'd0;
   localparam logic [1:0] ST_IDLE    = 2'd1;
   localparam logic [1:0] ST_COMPUTE = 2'd2;

   logic [1:0]       state, state_nx;
   logic [IDX_W-1:0] idx, idx_nx;
   logic [X_W-1:0]   cx, cx_nx;
   logic [Y_W-1:0]   cy, cy_nx;
   logic             sel, sel_nx;
   logic [7:0]       gen, gen_nx;
   logic             paused;
   logic             draw_prev, right_prev;
   logic             seed_we, comp_we;
   logic [CELLS-1:0] buf0, buf1;
   logic [CELLS-1:0] cur;

   logic             draw_rise, right_rise;
   logic             last_cell;
   logic [X_W-1:0]   xm, xp;
   logic [Y_W-1:0]   ym, yp;
   logic [3:0]       nbr_cnt;
   logic             next_cell;
   logic             pix_in_range;
   logic             pix_alive;
   logic [IDX_W-1:0] pix_idx;
   logic             unused_clk133;

   function automatic logic [IDX_W-1:0] cell_idx(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
      return IDX_W'(y) * IDX_W'(GRID_W) + IDX_W'(x);
   endfunction

   assign cur        = sel ? buf1 : buf0;
   assign draw_rise  = drawRequest & ~draw_prev;
   assign right_rise = right & ~right_prev;
   assign last_cell  = (idx == IDX_W'(CELLS - 1));

   // Toroidal neighbour coordinates of the cell being computed
   assign xm = (cx == '0) ? X_W'(GRID_W - 1) : cx - X_W'(1);
   assign xp = (cx == X_W'(GRID_W - 1)) ? '0 : cx + X_W'(1);
   assign ym = (cy == '0) ? Y_W'(GRID_H - 1) : cy - Y_W'(1);
   assign yp = (cy == Y_W'(GRID_H - 1)) ? '0 : cy + Y_W'(1);

   assign nbr_cnt = 4'(cur[cell_idx(xm, ym)]) + 4'(cur[cell_idx(cx, ym)]) + 4'(cur[cell_idx(xp, ym)])
                  + 4'(cur[cell_idx(xm, cy)])                             + 4'(cur[cell_idx(xp, cy)])
                  + 4'(cur[cell_idx(xm, yp)]) + 4'(cur[cell_idx(cx, yp)]) + 4'(cur[cell_idx(xp, yp)]);

   assign next_cell = (nbr_cnt == 4'd3) | (cur[idx] & (nbr_cnt == 4'd2));

   assign pix_in_range = displayActive & (column < 10'd640) & (row < 9'd480);
   assign pix_idx      = cell_idx(column[9:3], row[8:3]);
   assign pix_alive    = pix_in_range & cur[pix_idx];

   // Next-state and control decode
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      cx_nx    = cx;
      cy_nx    = cy;
      sel_nx   = sel;
      gen_nx   = gen;
      seed_we  = 1'b0;
      comp_we  = 1'b0;

      case (state)
         ST_SEED: begin
            seed_we = 1'b1;
            if (last_cell) begin
               state_nx = ST_IDLE;
               idx_nx   = '0;
               cx_nx    = '0;
               cy_nx    = '0;
            end else begin
               idx_nx = idx + IDX_W'(1);
               if (cx == X_W'(GRID_W - 1)) begin
                  cx_nx = '0;
                  cy_nx = cy + Y_W'(1);
               end else begin
                  cx_nx = cx + X_W'(1);
               end
            end
         end
         ST_IDLE: begin
            idx_nx = '0;
            cx_nx  = '0;
            cy_nx  = '0;
            if (left) begin
               state_nx = ST_SEED;
            end else if (draw_rise && !paused) begin
               state_nx = ST_COMPUTE;
            end
         end
         ST_COMPUTE: begin
            if (left) begin
               // Abort: the partially written next buffer is simply never selected
               state_nx = ST_SEED;
               idx_nx   = '0;
               cx_nx    = '0;
               cy_nx    = '0;
            end else begin
               comp_we = 1'b1;
               if (last_cell) begin
                  state_nx = ST_IDLE;
                  idx_nx   = '0;
                  cx_nx    = '0;
                  cy_nx    = '0;
                  sel_nx   = ~sel;
                  gen_nx   = gen + 8'd1;
               end else begin
                  idx_nx = idx + IDX_W'(1);
                  if (cx == X_W'(GRID_W - 1)) begin
                     cx_nx = '0;
                     cy_nx = cy + Y_W'(1);
                  end else begin
                     cx_nx = cx + X_W'(1);
                  end
               end
            end
         end
         default: begin
            state_nx = ST_SEED;
            idx_nx   = '0;
            cx_nx    = '0;
            cy_nx    = '0;
         end
      endcase
   end

   // State, buffers and pixel register
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_SEED;
         idx        <= '0;
         cx         <= '0;
         cy         <= '0;
         sel        <= 1'b0;
         gen        <= '0;
         paused     <= 1'b0;
         draw_prev  <= 1'b0;
         right_prev <= 1'b0;
         buf0       <= '0;
         buf1       <= '0;
         color      <= DEAD_COLOR;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         cx         <= cx_nx;
         cy         <= cy_nx;
         sel        <= sel_nx;
         gen        <= gen_nx;
         paused     <= paused ^ right_rise;
         draw_prev  <= drawRequest;
         right_prev <= right;
         if (seed_we) begin
            if (sel) buf1[idx] <= noise;
            else     buf0[idx] <= noise;
         end
         if (comp_we) begin
            if (sel) buf0[idx] <= next_cell;
            else     buf1[idx] <= next_cell;
         end
         if (clkDiv) begin
            color <= pix_alive ? LIVE_COLOR : DEAD_COLOR;
         end
      end
   end

   assign led = gen;

   // SDRAM held idle and deselected
   assign sd_A    = '0;
   assign sd_BA   = '0;
   assign sd_RAS  = 1'b1;
   assign sd_CAS  = 1'b1;
   assign sd_WE   = 1'b1;
   assign sd_CKE  = 1'b0;
   assign sd_CS   = 1'b1;
   assign sd_LDM  = 1'b1;
   assign sd_UDM  = 1'b1;
   assign sd_DQ   = 16'bz;
   assign sd_LDQS = 1'bz;
   assign sd_UDQS = 1'bz;

   assign unused_clk133 = clk133_p;

endmodule

// File: tb/tb_game_of_life_core.sv
// Directed bench for game_of_life_core: seeds patterns through noise, steps generations
// and scans the rendered pixels against a scoreboard of expected colours.
module tb_game_of_life_core;

   localparam logic [2:0] LIVE = 3'b010;
   localparam logic [2:0] DEAD = 3'b000;

   logic        clk = 1'b0;
   logic        rst, clkDiv, displayActive, noise, drawRequest, left, right, clk133_p;
   logic [8:0]  row;
   logic [9:0]  column;
   logic [2:0]  color;
   logic [7:0]  led;
   logic [12:0] sd_A;
   logic [1:0]  sd_BA;
   logic        sd_RAS, sd_CAS, sd_WE, sd_CKE, sd_CS, sd_LDM, sd_UDM;
   wire  [15:0] sd_DQ;
   wire         sd_LDQS, sd_UDQS;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [2:0] exp_q[$];
   logic       grid [0:4799];
   logic       pat  [0:4799];

   game_of_life_core dut (
      .clk(clk), .rst(rst), .clkDiv(clkDiv), .displayActive(displayActive), .noise(noise),
      .drawRequest(drawRequest), .left(left), .right(right), .row(row), .column(column),
      .color(color), .led(led), .clk133_p(clk133_p), .sd_A(sd_A), .sd_BA(sd_BA),
      .sd_RAS(sd_RAS), .sd_CAS(sd_CAS), .sd_WE(sd_WE), .sd_CKE(sd_CKE), .sd_CS(sd_CS),
      .sd_LDM(sd_LDM), .sd_UDM(sd_UDM), .sd_DQ(sd_DQ), .sd_LDQS(sd_LDQS), .sd_UDQS(sd_UDQS)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pop_check(input string tag);
      logic [2:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s: observed empty scoreboard expected an entry", tag);
      end else begin
         e = exp_q.pop_front();
         check(tag, 16'(color), 16'(e));
      end
   endtask

   // Present one pixel for a clock and compare the registered colour
   task automatic drive_pix(input string tag, input int r, input int c, input logic da,
                            input logic cd, input logic [2:0] exp);
      row           = 9'(r);
      column        = 10'(c);
      displayActive = da;
      clkDiv        = cd;
      exp_q.push_back(exp);
      @(negedge clk);
      pop_check(tag);
      clkDiv = 1'b0;
   endtask

   task automatic scan_grid(input string tag);
      int x, y;
      for (int i = 0; i < 4800; i++) begin
         x = i % 80;
         y = i / 80;
         drive_pix($sformatf("%s_x%0d_y%0d", tag, x, y),
                   y * 8 + int'($urandom_range(0, 7)), x * 8 + int'($urandom_range(0, 7)),
                   1'b1, 1'b1, grid[i] ? LIVE : DEAD);
      end
   endtask

   task automatic clear_pat();
      for (int i = 0; i < 4800; i++) pat[i] = 1'b0;
   endtask

   task automatic clear_grid();
      for (int i = 0; i < 4800; i++) grid[i] = 1'b0;
   endtask

   task automatic feed_pattern();
      for (int i = 0; i < 4800; i++) begin
         noise = pat[i];
         @(negedge clk);
      end
      noise = 1'b0;
      grid  = pat;
   endtask

   task automatic seed_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      feed_pattern();
   endtask

   task automatic seed_left();
      left = 1'b1;
      @(negedge clk);
      left = 1'b0;
      feed_pattern();
   endtask

   task automatic step();
      drawRequest = 1'b1;
      @(negedge clk);
      drawRequest = 1'b0;
      repeat (4800) @(negedge clk);
   endtask

   task automatic pulse_right();
      right = 1'b1;
      @(negedge clk);
      right = 1'b0;
      @(negedge clk);
   endtask

   task automatic life_step();
      logic nxt [0:4799];
      int   n;
      for (int y = 0; y < 60; y++) begin
         for (int x = 0; x < 80; x++) begin
            n = 0;
            for (int dy = -1; dy <= 1; dy++)
               for (int dx = -1; dx <= 1; dx++)
                  if (dx != 0 || dy != 0)
                     n += int'(grid[((y + dy + 60) % 60) * 80 + ((x + dx + 80) % 80)]);
            nxt[y * 80 + x] = (n == 3) || (grid[y * 80 + x] && n == 2);
         end
      end
      grid = nxt;
   endtask

   task automatic check_sdram(input string tag);
      check({tag, "_cs"},  16'(sd_CS),  16'd1);
      check({tag, "_cke"}, 16'(sd_CKE), 16'd0);
      check({tag, "_cmd"}, 16'({sd_RAS, sd_CAS, sd_WE}), 16'd7);
      check({tag, "_a"},   16'(sd_A),   16'd0);
      check({tag, "_dq"},  sd_DQ,       16'hzzzz);
   endtask

   initial begin
      rst = 1'b1; clkDiv = 1'b0; displayActive = 1'b0; noise = 1'b0; drawRequest = 1'b0;
      left = 1'b0; right = 1'b0; clk133_p = 1'b0; row = '0; column = '0;

      #1;
      check_sdram("sd_in_reset");
      @(negedge clk);
      check("reset_color", 16'(color), 16'(DEAD));
      check("reset_led",   16'(led),   16'd0);

      // All-zero seed
      clear_pat();
      seed_reset();
      check("zero_led", 16'(led), 16'd0);
      drive_pix("zero_col630", 0, 630, 1'b1, 1'b1, DEAD);
      drive_pix("col640_blank", 0, 640, 1'b0, 1'b1, DEAD);

      // Horizontal blinker
      clear_pat();
      pat[10 * 80 + 10] = 1'b1;
      pat[10 * 80 + 11] = 1'b1;
      pat[10 * 80 + 12] = 1'b1;
      seed_reset();
      drive_pix("blinker_seeded", 80, 80, 1'b1, 1'b1, LIVE);
      step();
      check("blinker_led", 16'(led), 16'd1);
      clear_grid();
      grid[9 * 80 + 11]  = 1'b1;
      grid[10 * 80 + 11] = 1'b1;
      grid[11 * 80 + 11] = 1'b1;
      scan_grid("blinker");
      drive_pix("blinker_px", 80, 88, 1'b1, 1'b1, LIVE);
      drive_pix("col_oob_alias", 64, 728, 1'b1, 1'b1, DEAD);
      drive_pix("da_low", 80, 88, 1'b0, 1'b1, DEAD);
      drive_pix("blinker_px2", 80, 88, 1'b1, 1'b1, LIVE);
      drive_pix("hold_strobe_low", 0, 0, 1'b1, 1'b0, LIVE);

      // Blinker straddling the x wrap
      clear_pat();
      pat[5 * 80 + 79] = 1'b1;
      pat[5 * 80 + 0]  = 1'b1;
      pat[5 * 80 + 1]  = 1'b1;
      seed_left();
      step();
      check("wrap_led", 16'(led), 16'd2);
      clear_grid();
      grid[4 * 80] = 1'b1;
      grid[5 * 80] = 1'b1;
      grid[6 * 80] = 1'b1;
      scan_grid("wrap");

      // Pause blocks stepping, unpause restores it
      pulse_right();
      step();
      check("pause_led", 16'(led), 16'd2);
      drive_pix("pause_px", 32, 0, 1'b1, 1'b1, LIVE);
      pulse_right();
      step();
      check("unpause_led", 16'(led), 16'd3);
      drive_pix("unpause_px_w", 40, 632, 1'b1, 1'b1, LIVE);
      drive_pix("unpause_px_n", 32, 0, 1'b1, 1'b1, DEAD);
      drive_pix("unpause_px_c", 40, 4, 1'b1, 1'b1, LIVE);

      // Random soup against the bench model
      for (int i = 0; i < 4800; i++) pat[i] = 1'($urandom_range(0, 1));
      seed_left();
      life_step();
      step();
      check("random_led", 16'(led), 16'd4);
      scan_grid("random");

      // Reseed aborts a compute in flight
      drawRequest = 1'b1;
      @(negedge clk);
      drawRequest = 1'b0;
      repeat (100) @(negedge clk);
      for (int i = 0; i < 4800; i++) pat[i] = 1'b1;
      left = 1'b1;
      @(negedge clk);
      left = 1'b0;
      feed_pattern();
      check("abort_led", 16'(led), 16'd4);
      scan_grid("abort");

      check_sdram("sd_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/game_of_life_core.md
# game_of_life_core

Conway's Game of Life engine and pixel renderer for the 640x480 VGA path. It holds an 80x60 toroidal cell grid in internal double-buffered storage and advances one generation per step request. It colours each active pixel from the cell under the beam. The DDR SDRAM pins are present for board compatibility and are held in a fixed idle state.

## Interface
- No parameters. Fixed values: grid 80x60 cells, 8x8 pixels per cell, live colour 3'b010, dead colour 3'b000.
- clk  in  1  sole clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clkDiv  in  1  pixel-rate strobe, sampled as data. `color` updates only on cycles where it is 1.
- displayActive  in  1  1 while the beam is in the visible area.
- noise  in  1  random bit used when seeding the grid.
- drawRequest  in  1  generation-step request; acts on its rising edge.
- left  in  1  reseed request, level-sensitive.
- right  in  1  pause toggle; acts on its rising edge.
- row  in  9  beam row, 0..479 visible.
- column  in  10  beam column, 0..639 visible.
- color  out  3  RGB pixel output.
- led  out  8  generation counter, bits [7:0].
- clk133_p  in  1  SDRAM clock input; unused.
- sd_A  out  13  constant 0.
- sd_BA  out  2  constant 0.
- sd_RAS, sd_CAS, sd_WE  out  1 each  constant 1 (NOP).
- sd_CKE  out  1  constant 0.
- sd_CS  out  1  constant 1 (deselected).
- sd_LDM, sd_UDM  out  1 each  constant 1.
- sd_DQ  inout  16  always high-Z.
- sd_LDQS, sd_UDQS  inout  1 each  always high-Z.

## Operation
- **Storage:** two 4800-bit buffers, `buf0` and `buf1`. The `sel` bit selects the current buffer; the other one is the next buffer.
- **Cell index:** index = y*80 + x, with x = column[9:3] and y = row[8:3].
- **Pixel output:** when the strobe loads, `color` becomes 3'b010 if all of the following hold, else 3'b000:
  - displayActive = 1
  - column < 640 and row < 480
  - the current-buffer cell at that index is alive
- **Neighbourhood:** the 8 neighbours wrap toroidally. x-1 of 0 is 79; x+1 of 79 is 0; y wraps the same way at 0 and 59.
- **Rule:** next = (count == 3) | (alive & count == 2).
- **FSM state SEED:** `idx` steps 0..4799, one cell per clk. Each cycle writes current[idx] <= noise. After idx 4799 the FSM goes to IDLE.
- **FSM state IDLE:**
  - left = 1 → SEED with idx = 0; left has priority.
  - Else, a rising edge on drawRequest while not paused → COMPUTE with idx = 0.
- **FSM state COMPUTE:** `idx` steps 0..4799, one cell per clk. Each cycle writes next[idx] <= rule(current). After idx 4799, in the same cycle: `sel` toggles, `gen` increments (8-bit wrap, 255 → 0), and the FSM goes to IDLE.
- **Reseed mid-compute:** left = 1 during COMPUTE aborts it. The FSM goes to SEED, `sel` and `gen` are unchanged, and the partial next buffer is discarded.
- **Pause:** a rising edge on `right` toggles `paused` in any state. Pausing does not abort a COMPUTE in progress.
- **Edge detection:** uses a one-register delay of each input (prev <= input each clk).
- **Ignored requests:** drawRequest edges during SEED or COMPUTE are dropped, not queued.
- **led:** always equals `gen`.

## Timing
- **Reset values:**
  - FSM = SEED, idx = 0, sel = 0, gen = 0, paused = 0
  - color = 0, led = 0, edge registers = 0
  - both buffers cleared to 0
- **After reset:** the block seeds automatically, 4800 clk cycles, then sits in IDLE.
- **Colour latency:** one clk from the strobe cycle, with row/column/displayActive sampled on that cycle. color holds its value while clkDiv = 0.
- **Step latency:** one generation takes 4800 clk cycles after the drawRequest edge is registered. The display switches to the new generation on the cycle after `sel` toggles.
- **Reset mid-operation:** the synchronous reset overrides any state on the next edge.
- **SDRAM pins:** constant from time 0, independent of reset.

## Test plan
- **Reset and seed with zeros:** rst = 1 for 1 clk, then 0, noise = 0, wait 4800 clk → FSM in IDLE, led = 0. column 630 with displayActive = 1 and clkDiv = 1 → color = 3'b000. column 640 with displayActive = 0 → color = 0.
- **Blinker:** preload horizontal cells (10,10), (11,10), (12,10). Pulse drawRequest, wait 4801 clk → live cells are exactly (11,9), (11,10), (11,11), led = 1. Pixel (row 80, column 88) → 3'b010.
- **Toroidal wrap:** blinker at (79,5), (0,5), (1,5), one step → live cells (0,4), (0,5), (0,6).
- **Pause:** pulse `right`, then pulse drawRequest → no COMPUTE, led unchanged. Pulse `right` again and step → led increments.
- **Reseed abort:** assert left 100 clk into COMPUTE with noise = 1 → FSM goes to SEED; after 4800 clk all cells are alive and gen is unchanged.
- **SDRAM idle:** at any time sd_CS = 1, sd_CKE = 0, RAS/CAS/WE = 1, sd_DQ = 16'hzzzz.
